// File: rtl/sat_ctr_bank.sv
// Bank of independent saturating/wrapping up/down counters sharing a live upper bound.
// Each channel is a sat_ctr_lane. The bank itself owns only the sticky error flag.

module sat_ctr_lane #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             unf,
  output logic             err_evt
);
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt, unf_nxt;

  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    err_evt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      if (load_val > limit) begin
        cnt_nxt = limit;
        err_evt = 1'b1;
      end else begin
        cnt_nxt = load_val;
      end
    end else if (cnt > limit) begin
      // limit was lowered under us: pull back into range whether or not enabled
      cnt_nxt = limit;
      err_evt = 1'b1;
    end else if (en) begin
      if (dir) begin
        if (cnt == limit) begin
          ovf_nxt = 1'b1;
          cnt_nxt = wrap ? '0 : limit;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (cnt == '0) begin
          unf_nxt = 1'b1;
          cnt_nxt = wrap ? limit : '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end
endmodule

module sat_ctr_bank #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH*CHANNELS-1:0] load_val,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic                      wrap,
  input  logic [WIDTH-1:0]          limit,
  output logic [WIDTH*CHANNELS-1:0] out,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic                      err
);
  logic [CHANNELS-1:0][WIDTH-1:0] lv, cnt_q;
  logic [CHANNELS-1:0]            err_evt;

  assign lv  = load_val;
  assign out = cnt_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    sat_ctr_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr[i]),
      .load     (load[i]),
      .en       (en[i]),
      .dir      (dir[i]),
      .wrap     (wrap),
      .load_val (lv[i]),
      .limit    (limit),
      .cnt      (cnt_q[i]),
      .ovf      (ovf[i]),
      .unf      (unf[i]),
      .err_evt  (err_evt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else      err <= err | (|err_evt);
  end
endmodule
